// File: rtl/led_scan_driver.sv
// rtl/led_scan_driver.sv - two-digit 7-segment scan driver with dead-time blanking
module led_scan_driver #(
    parameter int DIV   = 4096,
    parameter int BLANK = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic [6:0] h_seg,
    input  logic [6:0] l_seg,
    input  logic       lzb,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       frame
);

    localparam int MAX_COUNT = (DIV > BLANK) ? DIV : BLANK;
    localparam int CW        = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;

    localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);

    localparam logic [6:0] DARK_PAT = 7'b1111111;
    localparam logic [6:0] ZERO_PAT = 7'b0000001;
    localparam logic [1:0] AN_OFF   = 2'b11;
    localparam logic [1:0] AN_LOW   = 2'b10;
    localparam logic [1:0] AN_HIGH  = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        BLANK_L,
        SHOW_L,
        BLANK_H,
        SHOW_H
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [6:0]      cap_q, cap_d;
    logic            hide_q, hide_d;
    logic [1:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            frame_q, frame_d;

    // State, slot counter, captured pattern and registered pin drivers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cap_q   <= DARK_PAT;
            hide_q  <= 1'b0;
            an_q    <= AN_OFF;
            seg_q   <= DARK_PAT;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            hide_q  <= hide_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            frame_q <= frame_d;
        end
    end

    // Slot sequencing; patterns are captured only on the edge that enters a show slot
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        cap_d   = cap_q;
        hide_d  = hide_q;
        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
            cap_d   = DARK_PAT;
            hide_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = BLANK_L;
                    cnt_d   = '0;
                end
                BLANK_L: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = SHOW_L;
                        cnt_d   = '0;
                        cap_d   = l_seg;
                        hide_d  = 1'b0;
                    end
                end
                SHOW_L: begin
                    if (cnt_q == DIV_LAST) begin
                        state_d = BLANK_H;
                        cnt_d   = '0;
                    end
                end
                BLANK_H: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = SHOW_H;
                        cnt_d   = '0;
                        cap_d   = h_seg;
                        hide_d  = lzb && (h_seg == ZERO_PAT);
                    end
                end
                SHOW_H: begin
                    if (cnt_q == DIV_LAST) begin
                        state_d = BLANK_L;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Pin values for the upcoming state, so registered outputs line up with the state
    always_comb begin
        an_d    = AN_OFF;
        seg_d   = DARK_PAT;
        frame_d = 1'b0;
        case (state_d)
            BLANK_L: frame_d = (state_q != BLANK_L);
            SHOW_L: begin
                an_d  = AN_LOW;
                seg_d = cap_d;
            end
            SHOW_H: begin
                an_d  = hide_d ? AN_OFF : AN_HIGH;
                seg_d = cap_d;
            end
            default: begin
                an_d    = AN_OFF;
                seg_d   = DARK_PAT;
                frame_d = 1'b0;
            end
        endcase
    end

    assign an    = an_q;
    assign seg   = seg_q;
    assign frame = frame_q;

endmodule

// File: doc/led_scan_driver.md
# led_scan_driver

Time-multiplexed driver for the two-digit 7-segment display. It consumes the high and low segment patterns produced by the BCD-to-LED decoder and drives one shared segment bus plus two digit enables. Dead-time blanking sits between digits to suppress ghosting. Each pattern is captured at the start of its display slot so the display never tears. The block sits between the score/decoder logic and the board display pins.

## Interface
- DIV, 4096: clock cycles a digit is lit per slot; legal range ≥1.
- BLANK, 16: dead-time cycles before each digit slot, all digits off; legal range ≥1.
- CLK  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- EN  in  1  scan enable; 0 forces the display dark.
- H_SEG  in  7  high-digit pattern, active-low segments, bit 0 = segment 6 (middle) … bit 6 = segment 0 (top).
- L_SEG  in  7  low-digit pattern, same encoding.
- LZB  in  1  leading-zero blank: high digit dark when H_SEG equals the "0" pattern 7'b0000001.
- SEG  out  7  shared segment bus, active-low, same bit order as inputs.
- AN  out  2  digit enables, active-low; AN[1] = high digit, AN[0] = low digit.
- FRAME  out  1  one-cycle pulse at the start of every scan frame.

Clock and reset: one clock; reset is asynchronous and active-low.

## Operation
- States: IDLE, BLANK_L, SHOW_L, BLANK_H, SHOW_H. One slot counter, width clog2(max(DIV,BLANK)).
- IDLE: AN=2'b11, SEG=7'b1111111. Stay while EN=0. EN=1 → BLANK_L.
- BLANK_L: lasts BLANK cycles. AN=11, SEG=1111111. FRAME=1 in the first cycle only. Then → SHOW_L.
- SHOW_L: lasts DIV cycles. AN=2'b10, SEG = L_SEG captured on the entry edge. Then → BLANK_H.
- BLANK_H: lasts BLANK cycles, all dark. Then → SHOW_H.
- SHOW_H: lasts DIV cycles. SEG = H_SEG captured on the entry edge.
  - AN=2'b01, except AN=2'b11 when LZB=1 and the captured H_SEG==7'b0000001.
  - LZB is sampled on the same edge as H_SEG.
  - Then → BLANK_L, which starts a new frame.
- Input changes during a slot have no effect until the next capture edge.
- EN=0 in any state: the next edge enters IDLE, clears the counter, and drives AN=11 and SEG=1111111. Re-enabling always restarts at BLANK_L with FRAME.
- AN must never be 2'b00. No cycle may light a digit with the other digit's pattern.

## Timing
- All outputs are registered and change only on the rising edge of CLK (or on reset assertion). AN, SEG and FRAME reflect the current state in the same cycle.
- Reset values: state IDLE, counter 0, AN=2'b11, SEG=7'b1111111, FRAME=0, capture register 7'b1111111.
- Asserting reset mid-frame darkens the outputs immediately (asynchronously). After release, the block waits in IDLE until it samples EN=1.
- Latency from EN sampled 1 to the first BLANK_L cycle (FRAME=1): 1 clock. The first SHOW_L begins BLANK cycles later.
- Frame period: 2·(DIV+BLANK) cycles. FRAME pulses exactly once per period.
- Counter wrap: at terminal count (BLANK−1 or DIV−1) the state advances and the counter reloads 0 in the same edge.

## Test plan
- Reset/idle (DIV=4, BLANK=2). Hold RESET_N=0, then release with EN=0 → AN=11, SEG=7F, FRAME=0 for 20 cycles.
- Normal scan (DIV=4, BLANK=2). EN=1, L_SEG=7'b0010010 ("2"), H_SEG=7'b1001111 ("1"), LZB=0. Required per 12-cycle frame:
  - 2 dark cycles with FRAME in the first;
  - 4 cycles AN=10, SEG=0010010;
  - 2 dark cycles;
  - 4 cycles AN=01, SEG=1001111.
- Leading-zero blank. H_SEG=7'b0000001, LZB=1 → AN=11 throughout SHOW_H. With LZB=0 → AN=01, SEG=0000001.
- Mid-slot input change. Change L_SEG from "2" to "8" (7'b0000000) in the 2nd SHOW_L cycle → SEG stays 0010010 to the end of the slot. The next frame shows 0000000.
- Disable/re-enable. Drop EN in the 3rd SHOW_H cycle → dark on the next edge. Raise EN → FRAME after 1 cycle, and the scan restarts at BLANK_L.
- Async reset mid-frame. Assert RESET_N=0 during SHOW_L, off a clock edge → AN=11 and SEG=7F immediately. Checker runs throughout and confirms AN≠00 and FRAME period = 12.
